alu_decoder: RTL and testbench

- ALU control decoder for the single-cycle RISC-V core; sits between the main control decoder and the ALU.
- Maps the main decoder's ALUOp plus instruction fields funct3, funct7[5] and op[5] to a 3-bit ALUControl code.
- Provides a combinational output and a registered copy with an illegal-encoding flag for the pipeline/debug path.

---
 rtl/alu_decoder_pkg.sv | 33 +++
 rtl/alu_decoder_comb.sv | 50 +++++
 rtl/alu_decoder.sv | 61 ++++++
 tb/tb_alu_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_decoder_pkg.sv
// Shared constants and types for the ALU control decoder.
// Optional feature macro: ALU_DEC_EXT_EN (consumed in alu_decoder_comb).
package alu_decoder_pkg;

   typedef logic [2:0] alu_ctrl_t;

   // ALUControl codes presented to the ALU
   localparam alu_ctrl_t ALU_ADD = 3'b000;
   localparam alu_ctrl_t ALU_SUB = 3'b001;
   localparam alu_ctrl_t ALU_AND = 3'b010;
   localparam alu_ctrl_t ALU_OR  = 3'b011;
   localparam alu_ctrl_t ALU_XOR = 3'b100;
   localparam alu_ctrl_t ALU_SLT = 3'b101;
   localparam alu_ctrl_t ALU_SLL = 3'b110;
   localparam alu_ctrl_t ALU_SRL = 3'b111;

   // Operation classes from the main control decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   // funct3 field values (instruction bits [14:12])
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

endpackage : alu_decoder_pkg

// File: rtl/alu_decoder_comb.sv
// Pure combinational ALUOp/funct -> ALUControl mapping with illegal flag.
// Optional feature macro: ALU_DEC_EXT_EN adds xor, sll and srl decoding.
module alu_decoder_comb
   import alu_decoder_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       Op5,
   output alu_ctrl_t  ALUControl,
   output logic       Illegal
);

   // Decode the operation class, then funct3 for R/I-type arithmetic
   always_comb begin
      // NOTE: both outputs get a default before the case so every path assigns them and no latch is inferred.
      ALUControl = ALU_ADD;
      Illegal    = 1'b0;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALU_ADD;
         ALUOP_SUB: ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type (Op5=1) with funct7[5]=1 is sub; addi ignores funct7
               F3_ADD: ALUControl = (Op5 && funct7) ? ALU_SUB : ALU_ADD;
               F3_SLT: ALUControl = ALU_SLT;
               F3_OR:  ALUControl = ALU_OR;
               F3_AND: ALUControl = ALU_AND;
`ifdef ALU_DEC_EXT_EN
               F3_XOR: ALUControl = ALU_XOR;
               F3_SLL: begin
                  if (!funct7) ALUControl = ALU_SLL;
                  else         Illegal    = 1'b1;
               end
               F3_SR: begin
                  // sra (funct7=1) has no ALU code; flag it rather than alias to srl
                  if (!funct7) ALUControl = ALU_SRL;
                  else         Illegal    = 1'b1;
               end
               default: Illegal = 1'b1;  // sltu and unknown encodings
`else
               default: Illegal = 1'b1;  // shifts, sltu, xor unsupported
`endif
            endcase
         end
         default: Illegal = 1'b1;        // reserved class (and unknown ALUOp)
      endcase
   end

endmodule : alu_decoder_comb

// File: rtl/alu_decoder.sv
// ALU control decoder top: combinational decode plus optional output register.
// Optional feature macro: ALU_DEC_EXT_EN (see alu_decoder_comb).
module alu_decoder
   import alu_decoder_pkg::*;
#(
   parameter bit REG_OUT = 1'b1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] ALUOp,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       Op5,
   output logic [2:0] ALUControl,
   output logic [2:0] ALUControl_q,
   output logic       Illegal,
   output logic       Illegal_q
);

   alu_ctrl_t ctrl_d;
   logic      illegal_d;

   alu_decoder_comb u_comb (
      .ALUOp      (ALUOp),
      .funct3     (funct3),
      .funct7     (funct7),
      .Op5        (Op5),
      .ALUControl (ctrl_d),
      .Illegal    (illegal_d)
   );

   // Combinational outputs are independent of reset
   assign ALUControl = ctrl_d;
   assign Illegal    = illegal_d;

   generate
      if (REG_OUT) begin : g_reg
         alu_ctrl_t ctrl_q;
         logic      illegal_q;

         // Capture the decode every cycle; async reset clears to add / legal
         always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: non-blocking assignments here so all flops sample pre-edge values together.
            if (!rst_n) begin
               ctrl_q    <= ALU_ADD;
               illegal_q <= 1'b0;
            end else begin
               ctrl_q    <= ctrl_d;
               illegal_q <= illegal_d;
            end
         end

         assign ALUControl_q = ctrl_q;
         assign Illegal_q    = illegal_q;
      end else begin : g_noreg
         assign ALUControl_q = ctrl_d;
         assign Illegal_q    = illegal_d;
      end
   endgenerate

endmodule : alu_decoder

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: stimulus pushes expected responses,
// a monitor pops and compares them against the combinational or registered outputs.
// Honours ALU_DEC_EXT_EN for the extended-decode expectations.
module tb_alu_decoder;

`ifdef ALU_DEC_EXT_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [1:0] ALUOp;
   logic [2:0] funct3;
   logic       funct7;
   logic       Op5;
   logic [2:0] ALUControl;
   logic [2:0] ALUControl_q;
   logic       Illegal;
   logic       Illegal_q;

   alu_decoder #(.REG_OUT(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ALUOp        (ALUOp),
      .funct3       (funct3),
      .funct7       (funct7),
      .Op5          (Op5),
      .ALUControl   (ALUControl),
      .ALUControl_q (ALUControl_q),
      .Illegal      (Illegal),
      .Illegal_q    (Illegal_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] aluop;
      logic [2:0] f3;
      logic       op5;
      logic       f7;
      logic [2:0] ctrl;
      logic       ill;
      string      name;
   } vec_t;

   typedef struct {
      bit         is_reg;
      logic [2:0] ctrl;
      logic       ill;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   checks   = 0;
   int   failures = 0;

   // Bench-side view of what the output register should hold
   logic [2:0] model_ctrl;
   logic       model_ill;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got ctrl=%b ill=%b expected ctrl=%b ill=%b",
                  name, act[3:1], act[0], exp[3:1], exp[0]);
      end
   endtask

   // Monitor: on each sample event, drain the scoreboard against live outputs
   initial begin
      forever begin
         @(sample_ev);
         while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.is_reg) check(e.name, {ALUControl_q, Illegal_q}, {e.ctrl, e.ill});
            else          check(e.name, {ALUControl, Illegal}, {e.ctrl, e.ill});
         end
      end
   end

   function automatic vec_t mk(input logic [1:0] a, input logic [2:0] f3, input logic o5,
                               input logic f7, input logic [2:0] c, input logic il,
                               input string n);
      vec_t v;
      v.aluop = a; v.f3 = f3; v.op5 = o5; v.f7 = f7; v.ctrl = c; v.ill = il; v.name = n;
      return v;
   endfunction

   task automatic push(input bit is_reg, input logic [2:0] c, input logic il, input string n);
      exp_t e;
      e.is_reg = is_reg; e.ctrl = c; e.ill = il; e.name = n;
      exp_q.push_back(e);
   endtask

   // Drive one vector: comb result and held register checked before the edge, capture after
   task automatic apply(input vec_t v);
      @(negedge clk);
      ALUOp = v.aluop; funct3 = v.f3; Op5 = v.op5; funct7 = v.f7;
      #1;
      push(1'b0, v.ctrl, v.ill, v.name);
      push(1'b1, model_ctrl, model_ill, {v.name, "_hold_q"});
      ->sample_ev;
      @(posedge clk);
      #1;
      model_ctrl = v.ctrl;
      model_ill  = v.ill;
      push(1'b1, model_ctrl, model_ill, {v.name, "_q"});
      ->sample_ev;
   endtask

   vec_t vecs[$];

   initial begin
      rst_n = 1'b0;
      ALUOp = 2'b00; funct3 = 3'b000; funct7 = 1'b0; Op5 = 1'b0;
      model_ctrl = 3'b000;
      model_ill  = 1'b0;

      #2;
      push(1'b1, 3'b000, 1'b0, "reset_q");
      ->sample_ev;
      #6 rst_n = 1'b1;

      vecs.push_back(mk(2'b00, 3'b010, 1'b1, 1'b1, 3'b000, 1'b0, "aluop00_add"));
      vecs.push_back(mk(2'b01, 3'b010, 1'b1, 1'b1, 3'b001, 1'b0, "aluop01_sub"));
      vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0, "f3_000_sub"));
      vecs.push_back(mk(2'b10, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, "f3_000_op5_0_f7_1"));
      vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, "f3_000_op5_1_f7_0"));
      vecs.push_back(mk(2'b10, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, "f3_000_addi"));
      vecs.push_back(mk(2'b10, 3'b010, 1'b1, 1'b0, 3'b101, 1'b0, "slt"));
      vecs.push_back(mk(2'b10, 3'b111, 1'b1, 1'b0, 3'b010, 1'b0, "and"));
      vecs.push_back(mk(2'b11, 3'b010, 1'b1, 1'b0, 3'b000, 1'b1, "aluop11_rsvd"));
      vecs.push_back(mk(2'b10, 3'b100, 1'b1, 1'b0, EXT ? 3'b100 : 3'b000, !EXT, "xor"));
      vecs.push_back(mk(2'b10, 3'b101, 1'b1, 1'b0, EXT ? 3'b111 : 3'b000, !EXT, "srl"));
      vecs.push_back(mk(2'b10, 3'b001, 1'b1, 1'b0, EXT ? 3'b110 : 3'b000, !EXT, "sll"));
      vecs.push_back(mk(2'b10, 3'b101, 1'b1, 1'b1, 3'b000, 1'b1, "sra_illegal"));
      vecs.push_back(mk(2'b10, 3'b001, 1'b1, 1'b1, 3'b000, 1'b1, "sll_f7_illegal"));
      vecs.push_back(mk(2'b10, 3'b011, 1'b1, 1'b0, 3'b000, 1'b1, "sltu_illegal"));
      vecs.push_back(mk(2'b10, 3'b010, 1'b0, 1'b1, 3'b101, 1'b0, "slti"));
      vecs.push_back(mk(2'b10, 3'b110, 1'b1, 1'b0, 3'b011, 1'b0, "or"));

      foreach (vecs[i]) apply(vecs[i]);

      // Registers now hold 011; assert reset between edges
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_ctrl = 3'b000;
      model_ill  = 1'b0;
      push(1'b1, 3'b000, 1'b0, "rst_async_q");
      push(1'b0, 3'b011, 1'b0, "rst_comb_unaffected");
      ->sample_ev;
      @(posedge clk);
      #1;
      push(1'b1, 3'b000, 1'b0, "rst_held_q");
      ->sample_ev;
      #2 rst_n = 1'b1;
      #1;
      push(1'b1, 3'b000, 1'b0, "rst_release_before_edge_q");
      ->sample_ev;
      @(posedge clk);
      #1;
      push(1'b1, 3'b011, 1'b0, "rst_release_capture_q");
      ->sample_ev;

      // Bounded drain of anything the monitor has not consumed
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_decoder
